// File: rtl/ram16k_loader_pkg.sv
// ram16k_loader_pkg: shared state encoding and sizing for the RAM16K byte-stream loader
package ram16k_loader_pkg;
  localparam int ADDR_W = 15;
  localparam int DATA_W = 16;
  localparam int HDR_BYTES = 4;
  typedef enum logic [2:0] {IDLE, HDR, DATA_HI, DATA_LO, WRITE, DONE} state_t;
endpackage

// File: rtl/ram16k_loader.sv
// ram16k_loader: framed byte stream to consecutive RAM16K word writes with checksum
module ram16k_loader
  import ram16k_loader_pkg::*;
#(
  parameter int ADDR_W = ram16k_loader_pkg::ADDR_W,
  parameter int DATA_W = ram16k_loader_pkg::DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              rx_valid,
  input  logic [7:0]        rx_data,
  output logic              rx_ready,
  output logic [DATA_W-1:0] ram_in,
  output logic              ram_load,
  output logic [ADDR_W-1:0] ram_address,
  output logic              busy,
  output logic              done,
  output logic [DATA_W-1:0] checksum
);
  state_t              state_q;
  logic [1:0]          idx_q;
  logic [7:0]          hi_q;
  logic [15:0]         cnt_q;
  logic [DATA_W-1:0]   ram_in_q;
  logic [DATA_W-1:0]   sum_q;
  logic [ADDR_W-1:0]   addr_q;
  logic                ram_load_q;
  logic                done_q;
  logic                xfer;
  logic [15:0]         pair;
  assign rx_ready    = (state_q == HDR) || (state_q == DATA_HI) || (state_q == DATA_LO);
  assign busy        = rx_ready || (state_q == WRITE);
  assign xfer        = rx_valid & rx_ready;
  assign pair        = {hi_q, rx_data};
  assign ram_in      = ram_in_q;
  assign ram_load    = ram_load_q;
  assign ram_address = addr_q;
  assign done        = done_q;
  assign checksum    = sum_q;
  // Load sequencer: header capture, word assembly, one-cycle write strobe, bookkeeping on WRITE exit
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      idx_q      <= 2'd0;
      hi_q       <= 8'd0;
      cnt_q      <= 16'd0;
      ram_in_q   <= '0;
      sum_q      <= '0;
      addr_q     <= '0;
      ram_load_q <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      case (state_q)
        IDLE, DONE: if (start) begin
          state_q <= HDR;
          idx_q   <= 2'd0;
          sum_q   <= '0;
          done_q  <= 1'b0;
        end
        HDR: if (xfer) begin
          idx_q <= idx_q + 2'd1;
          hi_q  <= rx_data;
          if (idx_q == 2'd1) addr_q <= ADDR_W'(pair);
          if (idx_q == 2'(HDR_BYTES - 1)) begin
            cnt_q   <= pair;
            state_q <= (pair == 16'd0) ? DONE : DATA_HI;
            done_q  <= (pair == 16'd0);
          end
        end
        DATA_HI: if (xfer) begin
          hi_q    <= rx_data;
          state_q <= DATA_LO;
        end
        DATA_LO: if (xfer) begin
          ram_in_q   <= DATA_W'(pair);
          ram_load_q <= 1'b1;
          state_q    <= WRITE;
        end
        WRITE: begin
          ram_load_q <= 1'b0;
          sum_q      <= sum_q + ram_in_q;
          addr_q     <= addr_q + ADDR_W'(1);
          cnt_q      <= cnt_q - 16'd1;
          state_q    <= (cnt_q == 16'd1) ? DONE : DATA_HI;
          done_q     <= (cnt_q == 16'd1);
        end
        default: state_q <= IDLE;
      endcase
    end
  end
endmodule

// File: doc/ram16k_loader.md
# ram16k_loader

Byte-stream program/data loader that sits directly upstream of RAM16K and drives its `in`/`load`/`address` write port. Accepts a framed byte stream (4-byte header plus data) over a valid/ready handshake and assembles big-endian 16-bit words. Writes each word to consecutive RAM16K addresses and reports completion and a running checksum. Holds the CPU off the memory while a load is in progress.

## Interface
- `ADDR_W`, 15: RAM16K address width.
- `DATA_W`, 16: RAM word width.

- `clk` in 1: system clock, rising-edge.
- `reset` in 1: asynchronous, active-high reset.
- `start` in 1: one-cycle pulse that arms a new load; honoured only in IDLE or DONE.
- `rx_valid` in 1: a byte is offered on `rx_data`.
- `rx_data` in 8: stream byte.
- `rx_ready` out 1: loader accepts the byte this cycle; a transfer occurs when `rx_valid & rx_ready`.
- `ram_in` out DATA_W: word to RAM16K `in`.
- `ram_load` out 1: write strobe to RAM16K `load`.
- `ram_address` out ADDR_W: to RAM16K `address`.
- `busy` out 1: load in progress; the CPU must not access RAM16K while this is high.
- `done` out 1: set on load completion and held until the next `start` or `reset`.
- `checksum` out DATA_W: sum of all written words, mod 2^16.

## Operation
- Frame, in byte order: ADDR_HI, ADDR_LO, CNT_HI, CNT_LO, then CNT words, each as HI byte then LO byte.
- Start address is bit 14..0 of {ADDR_HI, ADDR_LO}. Bit 15 is discarded.
- CNT is a 16-bit word count. CNT = 0 is legal and writes nothing.
- States:
  - IDLE: on `start`, clear `checksum` and `done`, then go to HDR.
  - HDR: accept 4 bytes, tracked by a 2-bit byte index. After the 4th byte, go to DONE if CNT = 0, otherwise DATA_HI.
  - DATA_HI: accept a byte into the high byte of the word, then go to DATA_LO.
  - DATA_LO: accept a byte into the low byte of the word, then go to WRITE.
  - WRITE: drive `ram_load` = 1 for exactly one cycle. On exit, `checksum += word`, `address += 1` (wraps 0x7FFF -> 0x0000), `remaining -= 1`. Go to DATA_HI if remaining > 0, else DONE.
  - DONE: `done` = 1. On `start`, behave as in IDLE.
- `rx_ready` is 1 only in HDR, DATA_HI and DATA_LO; it is 0 in IDLE, WRITE and DONE.
- `busy` is 1 in HDR, DATA_HI, DATA_LO and WRITE.
- `start` is ignored while `busy`. A byte offered in IDLE or DONE is not consumed and stays pending.

## Timing
- All outputs are registered except `rx_ready` and `busy`, which decode directly from the state register.
- Reset values: state IDLE; `ram_load` 0; `ram_in` 0; `ram_address` 0; `checksum` 0; `done` 0; `busy` 0; `rx_ready` 0.
- `ram_in` and `ram_address` are stable for the whole WRITE cycle. RAM16K captures the word on the rising edge that ends WRITE.
- Per-word cost: 3 cycles minimum (DATA_HI, DATA_LO, WRITE). A stalled `rx_valid` extends DATA_HI or DATA_LO indefinitely.
- Latency: `done` rises the cycle after the last WRITE, or the cycle after CNT_LO when CNT = 0.
- `reset` mid-load: immediate return to IDLE and `ram_load` drops asynchronously. Words already written stay in RAM; the partial word is discarded.
- Address wrap does not terminate the load. The count alone governs termination.

## Structure
- Shared package holds:
  - the state enum: IDLE, HDR, DATA_HI, DATA_LO, WRITE, DONE;
  - `HDR_BYTES` = 4;
  - `ADDR_W` and `DATA_W` defaults.
- Single flat module. No sub-module is warranted, because the header byte index, word register, counters and checksum are each a few lines.
- Instantiated beside RAM16K with a 2:1 mux, selected by `busy`, between loader and CPU write ports.

## Test plan
- Reset, then `start`; frame 00 10 00 02 | 12 34 AB CD -> writes 0x1234@0x0010 and 0xABCD@0x0011; `done` = 1; `checksum` = 0xBE01; RAM readback matches.
- Wrap: address bytes 7F FF, count 00 02, data 00 01 00 02 -> writes at 0x7FFF then 0x0000; `checksum` = 0x0003.
- CNT = 0: frame 00 20 00 00 -> no `ram_load` pulse; `done` the cycle after the 4th byte; `checksum` = 0.
- Backpressure: `rx_valid` toggled randomly over a 3-word load -> `rx_ready` = 0 in every WRITE cycle; `ram_load` pulses are exactly 1 cycle wide; data is correct; no byte is lost or duplicated.
- Bit-15 discard and ignored `start`: address bytes 80 05 -> first write at 0x0005; a `start` pulse mid-load has no effect.
- `reset` asserted in DATA_LO of the 2nd word -> `ram_load` = 0 at once; state IDLE; the 1st word remains in RAM; the 2nd address is unwritten.
